// File: rtl/tb_lane_collector_pkg.sv
// Shared definitions for the multi-lane traceback symbol collector:
// symbol width and encodings, lane state, and width helper functions.
package tb_lane_collector_pkg;

    // Bits per alignment symbol emitted by a traceback engine.
    localparam int BP_WIDTH = 2;

    // Alignment symbol encodings as produced by the traceback lanes.
    typedef enum logic [BP_WIDTH-1:0] {
        SYM_MATCH    = 2'd0,
        SYM_MISMATCH = 2'd1,
        SYM_INSERT   = 2'd2,
        SYM_DELETE   = 2'd3
    } bp_sym_e;

    // Per-lane alignment state: IDLE until the first symbol of an alignment arrives.
    typedef enum logic [0:0] {
        LANE_IDLE   = 1'b0,
        LANE_ACTIVE = 1'b1
    } lane_state_e;

    // Lane id width; never less than one bit.
    function automatic int lane_id_w(input int n_lane);
        return (n_lane > 1) ? $clog2(n_lane) : 1;
    endfunction

    // Width needed to hold a symbol count in 0..pack inclusive.
    function automatic int sym_cnt_w(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/tb_lane_fifo.sv
// Per-lane word FIFO. Occupancy carries one extra bit so full and empty are
// distinguishable; the full flag is a flop so the lane stall never depends
// combinationally on the host handshake.
module tb_lane_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             full_q, full_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (occ_q == {(PTR_W+1){1'b0}});
    assign full  = full_q;
    assign rdata = mem_q[rptr_q];

    // Next-state for storage, pointers, occupancy and the registered full flag.
    always_comb begin
        mem_d     = mem_q;
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full_q | do_pop_s);
        if (do_push_s) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   occ_d = occ_q + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   occ_d = occ_q - {{PTR_W{1'b0}}, 1'b1};
            default: occ_d = occ_q;
        endcase
        full_d = (occ_d == (PTR_W+1)'(DEPTH));
    end

    // FIFO state registers; reset empties the buffer and clears storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/tb_lane_collector.sv
// Gathers alignment symbols from N_LANE traceback engines, packs each lane
// into PACK-symbol words, buffers them per lane and merges the lanes
// round-robin onto a single registered ready/valid host port.
module tb_lane_collector
    import tb_lane_collector_pkg::*;
#(
    parameter int N_LANE     = 4,
    parameter int BP_W       = BP_WIDTH,
    parameter int PACK       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LANE_W     = lane_id_w(N_LANE),
    parameter int CNT_W      = sym_cnt_w(PACK)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_LANE-1:0]      sym_valid,
    input  logic [N_LANE*BP_W-1:0] sym,
    input  logic [N_LANE-1:0]      lane_done,
    output logic [N_LANE-1:0]      lane_stall,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PACK*BP_W-1:0]   out_data,
    output logic [CNT_W-1:0]       out_cnt,
    output logic [LANE_W-1:0]      out_lane,
    output logic                   out_last
);

    localparam int DATA_W = PACK * BP_W;
    localparam int WORD_W = DATA_W + CNT_W + 1;

    logic [N_LANE-1:0] fifo_full_s;
    logic [N_LANE-1:0] fifo_empty_s;
    logic [N_LANE-1:0] fifo_pop_s;
    logic [N_LANE-1:0] lane_push_s;
    logic [WORD_W-1:0] push_word_s  [N_LANE];
    logic [WORD_W-1:0] fifo_rdata_s [N_LANE];

    // A full FIFO holds its lane; the flag is already a flop inside the FIFO.
    assign lane_stall = fifo_full_s;

    for (genvar i = 0; i < N_LANE; i++) begin : g_lane
        logic [DATA_W-1:0] buf_q, buf_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        lane_state_e       state_q, state_d;
        logic              acc_sym_s;
        logic              acc_done_s;
        logic [DATA_W-1:0] base_buf_s;
        logic [CNT_W-1:0]  base_cnt_s;
        logic [DATA_W-1:0] fill_buf_s;
        logic [CNT_W-1:0]  fill_cnt_s;
        logic              push_s;

        // Packer: insert the accepted symbol at the next slot, push on a full word or on done.
        always_comb begin
            acc_sym_s  = sym_valid[i] & ~fifo_full_s[i];
            acc_done_s = lane_done[i] & ~fifo_full_s[i];
            // A fresh alignment always starts packing at slot 0.
            if (state_q == LANE_IDLE) begin
                base_buf_s = '0;
                base_cnt_s = '0;
            end else begin
                base_buf_s = buf_q;
                base_cnt_s = cnt_q;
            end
            fill_buf_s = base_buf_s;
            fill_cnt_s = base_cnt_s;
            if (acc_sym_s) begin
                fill_buf_s[int'(base_cnt_s)*BP_W +: BP_W] = sym[i*BP_W +: BP_W];
                fill_cnt_s = base_cnt_s + CNT_W'(1);
            end else begin
                fill_cnt_s = base_cnt_s;
            end
            push_s = acc_done_s | (fill_cnt_s == CNT_W'(PACK));
            // Clearing the buffer on every push leaves unused slots zero for the next partial word.
            if (push_s) begin
                buf_d = '0;
                cnt_d = '0;
            end else begin
                buf_d = fill_buf_s;
                cnt_d = fill_cnt_s;
            end
        end

        // Lane state: becomes ACTIVE on the first symbol, returns to IDLE on an accepted done.
        always_comb begin
            state_d = state_q;
            case (state_q)
                LANE_IDLE: begin
                    if (acc_sym_s & ~acc_done_s) begin
                        state_d = LANE_ACTIVE;
                    end else begin
                        state_d = LANE_IDLE;
                    end
                end
                LANE_ACTIVE: begin
                    if (acc_done_s) begin
                        state_d = LANE_IDLE;
                    end else begin
                        state_d = LANE_ACTIVE;
                    end
                end
                default: state_d = LANE_IDLE;
            endcase
        end

        // Packer and lane-state registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                buf_q   <= '0;
                cnt_q   <= '0;
                state_q <= LANE_IDLE;
            end else begin
                buf_q   <= buf_d;
                cnt_q   <= cnt_d;
                state_q <= state_d;
            end
        end

        assign lane_push_s[i] = push_s;
        assign push_word_s[i] = {fill_buf_s, fill_cnt_s, acc_done_s};

        tb_lane_fifo #(
            .WIDTH (WORD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (lane_push_s[i]),
            .wdata (push_word_s[i]),
            .pop   (fifo_pop_s[i]),
            .rdata (fifo_rdata_s[i]),
            .full  (fifo_full_s[i]),
            .empty (fifo_empty_s[i])
        );
    end

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [CNT_W-1:0]    out_cnt_q,   out_cnt_d;
    logic [LANE_W-1:0]   out_lane_q,  out_lane_d;
    logic                out_last_q,  out_last_d;
    logic [LANE_W-1:0]   rr_q,        rr_d;
    logic                found_s;
    logic [LANE_W-1:0]   grant_s;
    logic                load_s;

    // Round-robin arbiter: refill the output register from the first non-empty lane at or after rr.
    always_comb begin
        found_s     = 1'b0;
        grant_s     = '0;
        fifo_pop_s  = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_lane_d  = out_lane_q;
        out_last_d  = out_last_q;
        rr_d        = rr_q;
        for (int k = 0; k < N_LANE; k++) begin
            if (!found_s && !fifo_empty_s[(int'(rr_q) + k) % N_LANE]) begin
                found_s = 1'b1;
                grant_s = LANE_W'((int'(rr_q) + k) % N_LANE);
            end else begin
                found_s = found_s;
            end
        end
        load_s = ~out_valid_q | out_ready;
        if (load_s) begin
            out_valid_d = found_s;
            if (found_s) begin
                {out_data_d, out_cnt_d, out_last_d} = fifo_rdata_s[grant_s];
                out_lane_d          = grant_s;
                fifo_pop_s[grant_s] = 1'b1;
                rr_d                = LANE_W'((int'(grant_s) + 1) % N_LANE);
            end else begin
                rr_d = rr_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_lane_q  <= '0;
            out_last_q  <= 1'b0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_lane_q  <= out_lane_d;
            out_last_q  <= out_last_d;
            rr_q        <= rr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign out_lane  = out_lane_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_tb_lane_collector.sv
// Directed, table-driven bench for the lane collector (N_LANE=4, BP_W=2, PACK=8, FIFO_DEPTH=4).
module tb_tb_lane_collector;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sym_valid;
    logic [7:0]  sym;
    logic [3:0]  lane_done;
    logic [3:0]  lane_stall;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_cnt;
    logic [1:0]  out_lane;
    logic        out_last;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tb_lane_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .lane_done  (lane_done),
        .lane_stall (lane_stall),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cnt    (out_cnt),
        .out_lane   (out_lane),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          lane;
        int          nsym;
        logic [15:0] syms;
        bit          done_last;
        int          nwords;
        logic [15:0] d0;
        int          c0;
        bit          l0;
        logic [15:0] d1;
        int          c1;
        bit          l1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sym_valid = 4'b0;
        sym       = 8'b0;
        lane_done = 4'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Hold the current drive until the lane is not stalled; acceptance is at the next posedge.
    task automatic wait_accept(input int l);
        int b;
        b = 0;
        while (lane_stall[l] && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) begin
            check("accept_timeout", 32'd1, 32'd0);
        end
    endtask

    task automatic send_lane(input int l, input int n, input logic [15:0] s, input bit done_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sym_valid[l]     = 1'b1;
            sym[l*2 +: 2]    = s[2*i +: 2];
            lane_done[l]     = done_last && (i == n - 1);
            wait_accept(l);
        end
        if (!done_last || n == 0) begin
            @(negedge clk);
            sym_valid[l] = 1'b0;
            lane_done[l] = 1'b1;
            wait_accept(l);
        end
        @(negedge clk);
        sym_valid[l] = 1'b0;
        lane_done[l] = 1'b0;
    endtask

    // Wait (bounded) for a valid word at a negedge, compare it, then step past its handshake.
    task automatic expect_word(input string name, input int lane, input logic [15:0] d,
                               input int c, input bit last);
        int b;
        b = 0;
        while (!out_valid && b < 60) begin
            @(negedge clk);
            b++;
        end
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_data"},  {16'd0, out_data},  {16'd0, d});
        check({name, "_cnt"},   {28'd0, out_cnt},   c);
        check({name, "_lane"},  {30'd0, out_lane},  lane);
        check({name, "_last"},  {31'd0, out_last},  {31'd0, last});
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] wexp [5];
        logic [15:0] s;

        vecs[0] = '{0, 8, 16'hE4E4, 1'b0, 2, 16'hE4E4, 8, 1'b0, 16'h0000, 0, 1'b1};
        vecs[1] = '{2, 3, 16'h001F, 1'b1, 1, 16'h001F, 3, 1'b1, 16'h0000, 0, 1'b0};
        vecs[2] = '{3, 0, 16'h0000, 1'b0, 1, 16'h0000, 0, 1'b1, 16'h0000, 0, 1'b0};
        vecs[3] = '{1, 8, 16'h1B2D, 1'b1, 1, 16'h1B2D, 8, 1'b1, 16'h0000, 0, 1'b0};
        vecs[4] = '{0, 5, 16'h0399, 1'b0, 1, 16'h0399, 5, 1'b1, 16'h0000, 0, 1'b0};
        vecs[5] = '{2, 1, 16'h0002, 1'b0, 1, 16'h0002, 1, 1'b1, 16'h0000, 0, 1'b0};

        out_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  {16'd0, out_data},  32'd0);
        check("rst_cnt",   {28'd0, out_cnt},   32'd0);
        check("rst_lane",  {30'd0, out_lane},  32'd0);
        check("rst_last",  {31'd0, out_last},  32'd0);
        check("rst_stall", {28'd0, lane_stall}, 32'd0);

        // Table-driven single-lane alignments
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            fork
                send_lane(vecs[v].lane, vecs[v].nsym, vecs[v].syms, vecs[v].done_last);
                begin
                    expect_word($sformatf("vec%0d_w0", v), vecs[v].lane, vecs[v].d0,
                                vecs[v].c0, vecs[v].l0);
                    if (vecs[v].nwords > 1) begin
                        expect_word($sformatf("vec%0d_w1", v), vecs[v].lane, vecs[v].d1,
                                    vecs[v].c1, vecs[v].l1);
                    end
                end
            join
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_no_extra", v), {31'd0, out_valid}, 32'd0);
        end

        // All four lanes complete a word in the same cycle: round-robin 0,1,2,3 back to back
        do_reset();
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            sym_valid = 4'hF;
            for (int l = 0; l < 4; l++) begin
                sym[l*2 +: 2] = 2'((j + l) % 4);
            end
        end
        @(negedge clk);
        sym_valid = 4'h0;
        begin
            int b;
            b = 0;
            while (!out_valid && b < 20) begin
                @(negedge clk);
                b++;
            end
        end
        wexp[0] = 16'hE4E4;
        wexp[1] = 16'h3939;
        wexp[2] = 16'h4E4E;
        wexp[3] = 16'h9393;
        for (int l = 0; l < 4; l++) begin
            check($sformatf("rr%0d_valid", l), {31'd0, out_valid}, 32'd1);
            check($sformatf("rr%0d_lane", l),  {30'd0, out_lane},  l);
            check($sformatf("rr%0d_data", l),  {16'd0, out_data},  {16'd0, wexp[l]});
            @(negedge clk);
        end
        check("rr_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: lane 1 streams 40 symbols with the host stalled
        do_reset();
        out_ready = 1'b0;
        wexp[0] = 16'hE4E4;
        wexp[1] = 16'h3939;
        wexp[2] = 16'h4E4E;
        wexp[3] = 16'h9393;
        wexp[4] = 16'hE4E4;
        for (int w = 0; w < 5; w++) begin
            s = wexp[w];
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                sym_valid[1] = 1'b1;
                sym[3:2]     = s[2*j +: 2];
                wait_accept(1);
            end
        end
        @(negedge clk);
        sym_valid[1] = 1'b0;
        @(negedge clk);
        check("bp_stall", {28'd0, lane_stall}, 32'h2);
        check("bp_valid_held", {31'd0, out_valid}, 32'd1);
        check("bp_data_held", {16'd0, out_data}, {16'd0, wexp[0]});
        out_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            expect_word($sformatf("bp_w%0d", w), 1, wexp[w], 8, 1'b0);
        end
        repeat (2) @(negedge clk);
        check("bp_no_extra", {31'd0, out_valid}, 32'd0);
        check("bp_stall_clear", {28'd0, lane_stall}, 32'd0);

        // Reset in the middle of a stream with words queued and a partial word in the packer
        do_reset();
        out_ready = 1'b0;
        send_lane(0, 8, 16'hE4E4, 1'b1);
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            sym_valid[0] = 1'b1;
            sym[1:0]     = 2'(j % 4);
            wait_accept(0);
        end
        @(negedge clk);
        sym_valid[0] = 1'b0;
        check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_stall", {28'd0, lane_stall}, 32'd0);
        check("mid_rst_cnt",   {28'd0, out_cnt},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        fork
            send_lane(0, 2, 16'h000D, 1'b1);
            expect_word("post_rst", 0, 16'h000D, 2, 1'b1);
        join
        repeat (3) @(negedge clk);
        check("post_rst_no_extra", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
